// File: rtl/debug_cmd_executor.sv
`default_nettype none
// ============================================================================
// Module      : debug_cmd_executor
// Description : Executes debug-port commands (halt/run/step and memory
//               read/write with auto-increment) behind a 4-phase REQX/ACKX
//               handshake, with a cycle timeout on CPU and memory waits.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_cmd_executor #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQX,
    input  logic [3:0]        OP,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              ACKX,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic              BUSY,
    output logic              HALT_REQ,
    output logic              STEP,
    input  logic              CPU_HALTED,
    output logic              MEM_REQ,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EXEC      = 3'd1;
    localparam logic [2:0] ST_WAIT_HALT = 3'd2;
    localparam logic [2:0] ST_MEM       = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_HALT    = 4'd1;
    localparam logic [3:0] OP_RUN     = 4'd2;
    localparam logic [3:0] OP_STEP    = 4'd3;
    localparam logic [3:0] OP_MEM_RD  = 4'd4;
    localparam logic [3:0] OP_MEM_WR  = 4'd5;
    localparam logic [3:0] OP_RD_INC  = 4'd6;

    localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT);

    logic              req_meta;
    logic              req_s;
    logic              armed;
    logic [2:0]        state;
    logic [3:0]        op_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        to_cnt;

    assign BUSY = (state != ST_IDLE);

    // Two-flop synchronizer for the asynchronous request line
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= REQX;
            req_s    <= req_meta;
        end
    end

    // Command FSM: capture, execute, wait for CPU/memory, then handshake out
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            op_l      <= 4'd0;
            addr_l    <= '0;
            wdata_l   <= '0;
            ptr       <= '0;
            to_cnt    <= 8'd0;
            ACKX      <= 1'b0;
            ERR       <= 1'b0;
            HALT_REQ  <= 1'b0;
            STEP      <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WR    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            RDATA     <= '0;
        end else begin
            STEP <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A request is only accepted after REQ_S was seen low,
                    // so a request still held high never re-triggers
                    if (!req_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed   <= 1'b0;
                        op_l    <= OP;
                        addr_l  <= ADDR;
                        wdata_l <= WDATA;
                        ERR     <= 1'b0;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    to_cnt <= 8'd0;
                    case (op_l)
                        OP_NOP: begin
                            ACKX  <= 1'b1;
                            state <= ST_ACK;
                        end
                        OP_HALT: begin
                            HALT_REQ <= 1'b1;
                            state    <= ST_WAIT_HALT;
                        end
                        OP_RUN: begin
                            HALT_REQ <= 1'b0;
                            ACKX     <= 1'b1;
                            state    <= ST_ACK;
                        end
                        OP_STEP: begin
                            if (CPU_HALTED) begin
                                STEP <= 1'b1;
                            end else begin
                                ERR <= 1'b1;
                            end
                            ACKX  <= 1'b1;
                            state <= ST_ACK;
                        end
                        OP_MEM_RD, OP_MEM_WR, OP_RD_INC: begin
                            if (!CPU_HALTED) begin
                                ERR   <= 1'b1;
                                ACKX  <= 1'b1;
                                state <= ST_ACK;
                            end else begin
                                MEM_REQ   <= 1'b1;
                                MEM_WR    <= (op_l == OP_MEM_WR);
                                MEM_WDATA <= wdata_l;
                                if (op_l == OP_RD_INC) begin
                                    MEM_ADDR <= ptr;
                                end else begin
                                    MEM_ADDR <= addr_l;
                                    ptr      <= addr_l;
                                end
                                state <= ST_MEM;
                            end
                        end
                        default: begin
                            ERR   <= 1'b1;
                            ACKX  <= 1'b1;
                            state <= ST_ACK;
                        end
                    endcase
                end
                ST_WAIT_HALT: begin
                    if (CPU_HALTED) begin
                        ACKX  <= 1'b1;
                        state <= ST_ACK;
                    end else if (to_cnt == TO_LIMIT) begin
                        ERR   <= 1'b1;
                        ACKX  <= 1'b1;
                        state <= ST_ACK;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_MEM: begin
                    if (MEM_READY) begin
                        MEM_REQ <= 1'b0;
                        if (op_l != OP_MEM_WR) begin
                            RDATA <= MEM_RDATA;
                        end
                        if (op_l == OP_RD_INC) begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                        ACKX  <= 1'b1;
                        state <= ST_ACK;
                    end else if (to_cnt == TO_LIMIT) begin
                        MEM_REQ <= 1'b0;
                        ERR     <= 1'b1;
                        ACKX    <= 1'b1;
                        state   <= ST_ACK;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        ACKX  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_cmd_executor
// Description : Self-checking bench for debug_cmd_executor: directed cases
//               plus randomized commands against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_cmd_executor;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQX = 1'b0;
    logic [3:0]  OP = 4'd0;
    logic [15:0] ADDR = 16'd0;
    logic [15:0] WDATA = 16'd0;
    logic        ACKX;
    logic [15:0] RDATA;
    logic        ERR;
    logic        BUSY;
    logic        HALT_REQ;
    logic        STEP;
    logic        CPU_HALTED = 1'b0;
    logic        MEM_REQ;
    logic        MEM_WR;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA = 16'd0;
    logic        MEM_READY = 1'b0;

    debug_cmd_executor #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(255)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQX(REQX), .OP(OP), .ADDR(ADDR),
        .WDATA(WDATA), .ACKX(ACKX), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
        .HALT_REQ(HALT_REQ), .STEP(STEP), .CPU_HALTED(CPU_HALTED),
        .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Environment memory (what the memory responder serves) and the model's
    // own view of memory; both start from the same background pattern.
    logic [15:0] env_mem [int];
    logic [15:0] mdl_mem [int];
    logic [15:0] m_ptr = 16'd0;
    logic        m_halt = 1'b0;
    logic [15:0] m_rdata = 16'd0;

    // Observations from the last command
    int          got_ack, n_step, n_req_rise, n_resp, req_high, rel_cycles;
    logic [15:0] acc_addr, acc_wdata;
    logic        acc_wr, acc_stable;

    function automatic logic [15:0] bg(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] env_rd(input logic [15:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : bg(a);
    endfunction

    function automatic logic [15:0] mdl_rd(input logic [15:0] a);
        return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : bg(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one request and play CPU/memory until ACKX (bounded)
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, input int halt_at, input int lat);
        logic prev_req;
        OP = op; ADDR = addr; WDATA = wdata; REQX = 1'b1;
        got_ack = 0; n_step = 0; n_req_rise = 0; n_resp = 0; req_high = 0;
        acc_stable = 1'b1; prev_req = 1'b0;
        for (int cyc = 1; cyc <= 600 && got_ack == 0; cyc++) begin
            @(posedge CLK); #1;
            if (halt_at >= 0 && cyc == halt_at) CPU_HALTED = 1'b1;
            if (STEP) n_step++;
            if (MEM_READY) begin
                MEM_READY = 1'b0;
            end else if (MEM_REQ) begin
                if (!prev_req) begin
                    n_req_rise++;
                    acc_addr = MEM_ADDR; acc_wr = MEM_WR; acc_wdata = MEM_WDATA;
                end else if (MEM_ADDR !== acc_addr || MEM_WR !== acc_wr || MEM_WDATA !== acc_wdata) begin
                    acc_stable = 1'b0;
                end
                if (lat >= 0 && req_high == lat) begin
                    n_resp++;
                    MEM_READY = 1'b1;
                    MEM_RDATA = env_rd(MEM_ADDR);
                    if (MEM_WR) env_mem[int'(MEM_ADDR)] = MEM_WDATA;
                end
                req_high++;
            end
            prev_req = MEM_REQ;
            if (ACKX) got_ack = 1;
        end
    endtask

    task automatic release_req();
        REQX = 1'b0;
        rel_cycles = 0;
        while (ACKX === 1'b1 && rel_cycles < 20) begin
            @(posedge CLK); #1;
            rel_cycles++;
            if (STEP) n_step++;
        end
    endtask

    // Model the command, run it and compare everything observable
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic halted,
                           input int halt_at, input int lat);
        logic        e_err, e_acc, e_wr, e_step;
        logic [15:0] e_addr;
        e_err = 1'b0; e_acc = 1'b0; e_wr = 1'b0; e_step = 1'b0; e_addr = 16'd0;
        CPU_HALTED = halted;
        case (op)
            4'd0: ;
            4'd1: begin m_halt = 1'b1; e_err = !(halted || halt_at >= 0); end
            4'd2: m_halt = 1'b0;
            4'd3: begin e_err = !halted; e_step = halted; end
            4'd4, 4'd5, 4'd6: begin
                if (!halted) begin
                    e_err = 1'b1;
                end else begin
                    e_addr = (op == 4'd6) ? m_ptr : addr;
                    if (op != 4'd6) m_ptr = addr;
                    e_acc = 1'b1;
                    e_wr = (op == 4'd5);
                    if (lat < 0) begin
                        e_err = 1'b1;
                    end else begin
                        if (op == 4'd5) mdl_mem[int'(e_addr)] = wdata;
                        else m_rdata = mdl_rd(e_addr);
                        if (op == 4'd6) m_ptr = e_addr + 16'd1;
                    end
                end
            end
            default: e_err = 1'b1;
        endcase
        do_cmd(op, addr, wdata, halt_at, lat);
        chk({tag, ".ackx"}, 32'(got_ack), 32'd1);
        chk({tag, ".err"}, 32'(ERR), 32'(e_err));
        chk({tag, ".halt_req"}, 32'(HALT_REQ), 32'(m_halt));
        chk({tag, ".rdata"}, 32'(RDATA), 32'(m_rdata));
        chk({tag, ".mem_req_count"}, 32'(n_req_rise), 32'(e_acc));
        chk({tag, ".mem_ready_count"}, 32'(n_resp), 32'(e_acc && lat >= 0));
        if (e_acc) begin
            chk({tag, ".mem_addr"}, 32'(acc_addr), 32'(e_addr));
            chk({tag, ".mem_wr"}, 32'(acc_wr), 32'(e_wr));
            chk({tag, ".mem_stable"}, 32'(acc_stable), 32'd1);
            if (e_wr) chk({tag, ".mem_wdata"}, 32'(acc_wdata), 32'(wdata));
        end
        release_req();
        chk({tag, ".ackx_low"}, 32'(ACKX), 32'd0);
        chk({tag, ".step_pulses"}, 32'(n_step), 32'(e_step));
        chk({tag, ".busy_idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic [3:0]  op_tab [11];
        logic [3:0]  rop;
        logic [15:0] raddr;
        logic        rhalt;
        int          w;
        op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7, 4'd15};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.ackx", 32'(ACKX), 0);
        chk("rst.err", 32'(ERR), 0);
        chk("rst.busy", 32'(BUSY), 0);
        chk("rst.halt_req", 32'(HALT_REQ), 0);
        chk("rst.step", 32'(STEP), 0);
        chk("rst.mem_req", 32'(MEM_REQ), 0);
        chk("rst.mem_wr", 32'(MEM_WR), 0);
        chk("rst.rdata", 32'(RDATA), 0);
        chk("rst.mem_addr", 32'(MEM_ADDR), 0);
        chk("rst.mem_wdata", 32'(MEM_WDATA), 0);
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // HALT with CPU halting 5 cycles after the request; ACKX drops within 3
        run_cmd("halt", 4'd1, 16'd0, 16'd0, 1'b0, 5, 0);
        chk("halt.release_cycles", 32'(rel_cycles <= 3), 1);

        // Memory read at 0x1234 with a 3-cycle memory
        env_mem[int'(16'h1234)] = 16'hBEEF;
        mdl_mem[int'(16'h1234)] = 16'hBEEF;
        run_cmd("rd1234", 4'd4, 16'h1234, 16'h0000, 1'b1, -1, 3);
        chk("rd1234.rdata_beef", 32'(RDATA), 32'hBEEF);

        // Write at 0xFFFF then two auto-increment reads (wrap to 0x0000)
        run_cmd("wr_ffff", 4'd5, 16'hFFFF, 16'hC0DE, 1'b1, -1, 1);
        run_cmd("inc0", 4'd6, 16'h0000, 16'h0000, 1'b1, -1, 0);
        chk("inc0.addr_ffff", 32'(acc_addr), 32'hFFFF);
        chk("inc0.rdata_c0de", 32'(RDATA), 32'hC0DE);
        run_cmd("inc1", 4'd6, 16'h0000, 16'h0000, 1'b1, -1, 2);
        chk("inc1.addr_wrap", 32'(acc_addr), 32'h0000);

        // Memory never ready: timeout after about 255 cycles
        run_cmd("timeout", 4'd4, 16'h0042, 16'h0000, 1'b1, -1, -1);
        chk("timeout.req_cycles", 32'(req_high >= 255 && req_high <= 256), 1);

        // Illegal op and memory access while CPU running
        run_cmd("illegal", 4'hF, 16'h0000, 16'h0000, 1'b1, -1, 0);
        run_cmd("wr_running", 4'd5, 16'h0010, 16'h1111, 1'b0, -1, 0);

        // Step with and without a halted CPU, then RUN
        run_cmd("step_ok", 4'd3, 16'h0000, 16'h0000, 1'b1, -1, 0);
        run_cmd("step_err", 4'd3, 16'h0000, 16'h0000, 1'b0, -1, 0);
        run_cmd("run", 4'd2, 16'h0000, 16'h0000, 1'b0, -1, 0);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            rop   = op_tab[$urandom_range(10, 0)];
            raddr = ($urandom_range(3, 0) == 0) ? 16'(16'hFFFE + $urandom_range(1, 0))
                                                : 16'($urandom);
            rhalt = ($urandom_range(3, 0) != 0);
            if (rop == 4'd1 || rop == 4'd4 || rop == 4'd5) rhalt = 1'b1;
            run_cmd("rand", rop, raddr, 16'($urandom), rhalt, -1, int'($urandom_range(5, 0)));
        end

        // Reset while a memory access is pending
        run_cmd("halt2", 4'd1, 16'd0, 16'd0, 1'b1, -1, 0);
        CPU_HALTED = 1'b1;
        OP = 4'd4; ADDR = 16'h0777; REQX = 1'b1;
        w = 0;
        while (MEM_REQ !== 1'b1 && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        chk("rstmem.entered", 32'(MEM_REQ), 1);
        repeat (10) @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        chk("rstmem.mem_req", 32'(MEM_REQ), 0);
        chk("rstmem.ackx", 32'(ACKX), 0);
        chk("rstmem.busy", 32'(BUSY), 0);
        chk("rstmem.halt_req", 32'(HALT_REQ), 0);
        REQX = 1'b0;
        RESET_N = 1'b1;
        m_ptr = 16'd0; m_halt = 1'b0; m_rdata = 16'd0;
        repeat (3) @(posedge CLK);
        #1;
        run_cmd("post_rst", 4'd4, 16'h0123, 16'h0000, 1'b1, -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
